// File: rtl/dot_mac_pkg.sv
// Shared types and defaults for the dot_product_mac streaming multiply-accumulate engine.
package dot_mac_pkg;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_VEC_LEN = 3;
  localparam int DEF_ACC_W   = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Width needed to count 0..n-1, never narrower than one bit so VEC_LEN=1 still has a counter.
  function automatic int clog2(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dot_product_mac_onehot_enc.sv
// One-hot to binary operand decoder; zero-hot or multi-hot inputs decode to 0 and raise err.
module onehot_enc #(
  parameter int DATA_W = 4
) (
  input  logic [2**DATA_W-1:0] onehot,
  output logic [DATA_W-1:0]    value,
  output logic                 err
);

  logic found;

  always_comb begin
    value = '0;
    err   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2**DATA_W; i++) begin
      if (onehot[i]) begin
        if (found) err = 1'b1;
        found = 1'b1;
        value = DATA_W'(i);
      end
    end
    if (!found) err = 1'b1;
    if (err) value = '0;
  end

endmodule

// File: rtl/dot_product_mac.sv
// Sequential dot-product MAC with valid/ready on both sides.
// Define ONEHOT_INPUT_EN to take one-hot operands (2**DATA_W bits) and report illegal codes on out_err.
module dot_product_mac
  import dot_mac_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int ACC_W   = DEF_ACC_W,
`ifdef ONEHOT_INPUT_EN
  localparam int IN_W = 2**DATA_W
`else
  localparam int IN_W = DATA_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int CNT_W  = clog2(VEC_LEN);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic               ovf_r;
  logic               err_r;
  logic [DATA_W-1:0]  a_val;
  logic [DATA_W-1:0]  b_val;
  logic               err_now;
  logic [PROD_W-1:0]  prod;
  logic [SUM_W-1:0]   sum_ext;

`ifdef ONEHOT_INPUT_EN
  logic err_a;
  logic err_b;

  onehot_enc #(.DATA_W(DATA_W)) u_enc_a (.onehot(in_a), .value(a_val), .err(err_a));
  onehot_enc #(.DATA_W(DATA_W)) u_enc_b (.onehot(in_b), .value(b_val), .err(err_b));

  assign err_now = err_a | err_b;
`else
  assign a_val   = in_a;
  assign b_val   = in_b;
  assign err_now = 1'b0;
`endif

  // The extra top bit of sum_ext is the carry out of the wrapping accumulator.
  assign prod     = PROD_W'(a_val) * PROD_W'(b_val);
  assign sum_ext  = {1'b0, acc} + SUM_W'(prod);
  assign in_ready = (state == ST_ACCUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACCUM;
      acc       <= '0;
      count     <= '0;
      ovf_r     <= 1'b0;
      err_r     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (in_valid) begin
            if (count == LAST) begin
              out_data  <= sum_ext[ACC_W-1:0];
              out_ovf   <= ovf_r | sum_ext[ACC_W];
              out_err   <= err_r | err_now;
              out_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              ovf_r     <= 1'b0;
              err_r     <= 1'b0;
              state     <= ST_HOLD;
            end else begin
              acc   <= sum_ext[ACC_W-1:0];
              ovf_r <= ovf_r | sum_ext[ACC_W];
              err_r <= err_r | err_now;
              count <= count + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule
